gain_ramp: RTL and testbench
============================

# gain_ramp

Output volume stage between the mixer and the I2S transmitter. Once per audio frame it takes the mixed 24-bit sample and multiplies it by a 16-bit gain, using a serial shift-add multiplier clocked on the bit clock. The gain slews toward its target by a fixed step per frame, which avoids zipper noise and power-up clicks. The result is rounded and presented as a held output sample for i2s_tx.

## Interface
Parameters:
- BITSIZE, 24, sample width, two's complement
- GAINSIZE, 16, gain width, unsigned Q2.(GAINSIZE-2); unity = 1<<(GAINSIZE-2)
- STEP, 16, gain slew per frame, in gain LSBs

Ports:
- bclk  in  1  bit clock; only clock, all logic on posedge
- reset  in  1  synchronous, active-high
- lrclk  in  1  frame clock, synchronous to bclk; rising edge starts a sample
- in  in  BITSIZE  signed input sample
- target_gain  in  GAINSIZE  requested gain
- mute  in  1  1 = effective target is 0
- out  out  BITSIZE  signed output sample, held between updates
- gain  out  GAINSIZE  current (slewed) gain
- busy  out  1  multiply in progress
- clip  out  1  one-cycle pulse when the output saturated

## Operation
- Frame detect: lrclk_q <= lrclk; rise = lrclk & ~lrclk_q.
- FSM states:
  - IDLE: on rise, capture in, update gain, load counter = 0, go to MULT.
  - MULT: runs GAINSIZE cycles; go to SAT after the cycle where counter == GAINSIZE-1.
  - SAT: write out, go to IDLE.
- A rise seen in MULT or SAT is ignored. It cannot occur with at least 64 bclk per frame.
- Gain slew (applied in the capture cycle; the multiply uses the new value):
  - tgt = mute ? 0 : target_gain.
  - If gain < tgt: gain = min(gain+STEP, tgt).
  - If gain > tgt: gain = max(gain-STEP, tgt).
  - Compute at GAINSIZE+1 bits so there is no wrap. Gain never overshoots tgt.
- Multiply:
  - 40-bit signed accumulator (BITSIZE+GAINSIZE), cleared at capture.
  - MULT cycle i: if gain[i], acc += sext(sample) << i.
- Round and shift: r = (acc + (1<<(GAINSIZE-3))) >>> (GAINSIZE-2). This is arithmetic shift with round-half-up.
- Output conversion: see Configuration.
- Changing target_gain or mute mid-ramp takes effect at the next frame. The gain may reverse direction.

## Timing
- E0 = posedge at which rise is sampled.
- E0: capture and gain update; busy <= 1.
- E1..E16: shift-add steps.
- E17: out and clip written; busy <= 0.
- Latency: out changes 17 bclk edges after E0, i.e. GAINSIZE+1.
- clip is high for exactly the cycle after E17.
- Reset values:
  - out = 0, gain = 0, busy = 0, clip = 0
  - state IDLE, lrclk_q = 0, accumulator = 0
- Gain starts at 0, so every power-up ramps in from silence.
- If lrclk is high at reset release, the first edge counts as a rise.
- Reset mid-MULT/SAT aborts the operation: out = 0 and no clip pulse.

## Configuration
- GAIN_RAMP_SAT_EN defined:
  - r > 2^(BITSIZE-1)-1 → out = 0x7FFFFF, clip pulse.
  - r < -2^(BITSIZE-1) → out = 0x800000, clip pulse.
  - Otherwise out = r.
- Undefined:
  - out = r[BITSIZE-1:0] (wraps).
  - clip tied 0; comparators removed.

## Structure
- Shared package gain_ramp_pkg:
  - state encoding (IDLE, MULT, SAT)
  - FRAC = GAINSIZE-2
  - UNITY_GAIN = 16'h4000
  - accumulator width constant
- Sub-module gain_slew: combinational gain, tgt, STEP → next gain. It is reused by future per-channel volume blocks.

## Test plan
- Reset release, target 0x4000, mute 0 → gain rises +16 per frame and reaches exactly 0x4000 at frame 1024, then holds.
- Gain at unity, in 0x123456 → out 0x123456 at E17. busy high over E0..E16, low at E17.
- Gain 0x8000:
  - With macro: in 0x500000 → out 0x7FFFFF and clip pulse; in 0xA00000 → out 0x800000 and clip pulse.
  - Without macro: in 0x500000 → out 0xA00000, clip 0.
- Gain 0x2000:
  - in 0x000003 → out 0x000002
  - in 0xFFFFFD → out 0xFFFFFF
  - in 0x000001 → out 0x000001
- At unity, assert mute → gain falls 16 per frame to 0 in 1024 frames, then out = 0. Deassert mute at frame 512 → gain reverses and climbs from 0x2000.
- Assert reset at E8 of a multiply → next edge out 0, gain 0, busy 0. No clip pulse and no stale output after release.

Source files
------------

// File: rtl/gain_ramp_pkg.sv
// Purpose: shared constants for the gain_ramp output volume stage.
// Latency: none (definitions only).
// Backpressure: none.
//   FSM state encoding, fractional gain bits, unity gain and accumulator width.
package gain_ramp_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MULT = 2'd1;
  localparam logic [1:0] ST_SAT  = 2'd2;

  // Default 24-bit sample, 16-bit Q2.14 gain
  localparam int          GAINSIZE_DFLT = 16;
  localparam int          FRAC          = GAINSIZE_DFLT - 2;
  localparam logic [15:0] UNITY_GAIN    = 16'h4000;
  localparam int          ACC_W         = 24 + GAINSIZE_DFLT;

endpackage

// File: rtl/gain_ramp_gain_slew.sv
// Purpose: next-gain computation, one STEP toward tgt without overshoot.
// Latency: combinational.
// Backpressure: none.
//   gain      in  current gain
//   tgt       in  effective target gain (already forced to 0 when muted)
//   gain_next out gain after one slew step
module gain_slew #(
  parameter int GAINSIZE = 16,
  parameter int STEP     = 16
) (
  input  logic [GAINSIZE-1:0] gain,
  input  logic [GAINSIZE-1:0] tgt,
  output logic [GAINSIZE-1:0] gain_next
);

  localparam logic [GAINSIZE:0] STEP_W = (GAINSIZE+1)'(STEP);

  // One extra bit so neither the rising sum nor the falling limit wraps.
  logic [GAINSIZE:0] up_sum;
  logic [GAINSIZE:0] dn_lim;

  always_comb begin
    up_sum    = {1'b0, gain} + STEP_W;
    dn_lim    = {1'b0, tgt} + STEP_W;
    gain_next = gain;
    if (gain < tgt) begin
      gain_next = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[GAINSIZE-1:0];
    end else if (gain > tgt) begin
      // gain - STEP <= tgt  <=>  gain <= tgt + STEP
      gain_next = ({1'b0, gain} <= dn_lim) ? tgt : (gain - STEP_W[GAINSIZE-1:0]);
    end
  end

endmodule

// File: rtl/gain_ramp.sv
// Purpose: per-frame sample x slewed-gain via serial shift-add, rounded and held.
// Latency: out/clip update GAINSIZE+1 bclk after the lrclk rise is sampled.
// Backpressure: none; lrclk rises seen while busy are ignored.
//   bclk, reset (sync, active-high), lrclk frame clock, in sample,
//   target_gain/mute requested gain, out held sample, gain current gain,
//   busy multiply in progress, clip one-cycle saturation pulse.
//   Optional saturation enabled by defining GAIN_RAMP_SAT_EN (wraps otherwise).
module gain_ramp
  import gain_ramp_pkg::*;
#(
  parameter int BITSIZE  = 24,
  parameter int GAINSIZE = 16,
  parameter int STEP     = 16
) (
  input  logic                       bclk,
  input  logic                       reset,
  input  logic                       lrclk,
  input  logic signed [BITSIZE-1:0]  in,
  input  logic        [GAINSIZE-1:0] target_gain,
  input  logic                       mute,
  output logic        [BITSIZE-1:0]  out,
  output logic        [GAINSIZE-1:0] gain,
  output logic                       busy,
  output logic                       clip
);

  localparam int AW = BITSIZE + GAINSIZE;
  localparam int FR = GAINSIZE - 2;
  localparam int CW = $clog2(GAINSIZE);
  localparam logic signed [AW-1:0] RND = {{(AW-1){1'b0}}, 1'b1} << (FR - 1);
`ifdef GAIN_RAMP_SAT_EN
  localparam logic signed [AW-1:0] MAX_V = {{(GAINSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V = {{(GAINSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};
`endif

  logic [1:0]               state_q, state_d;
  logic                     lrclk_q, lrclk_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [BITSIZE-1:0]       sample_q, sample_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [GAINSIZE-1:0]      gain_q, gain_d;
  logic [BITSIZE-1:0]       out_q, out_d;
  logic                     busy_q, busy_d;
  logic                     clip_q, clip_d;

  logic                     rise;
  logic [GAINSIZE-1:0]      tgt;
  logic [GAINSIZE-1:0]      gain_next;
  logic signed [AW-1:0]     sample_ext;
`ifdef GAIN_RAMP_SAT_EN
  logic signed [AW-1:0]     rnd;
`endif

  assign tgt = mute ? '0 : target_gain;

  gain_slew #(
    .GAINSIZE (GAINSIZE),
    .STEP     (STEP)
  ) u_gain_slew (
    .gain      (gain_q),
    .tgt       (tgt),
    .gain_next (gain_next)
  );

  always_comb begin
    lrclk_d    = lrclk;
    rise       = lrclk & ~lrclk_q;
    sample_ext = {{GAINSIZE{sample_q[BITSIZE-1]}}, sample_q};
    state_d    = state_q;
    cnt_d      = cnt_q;
    sample_d   = sample_q;
    acc_d      = acc_q;
    gain_d     = gain_q;
    out_d      = out_q;
    busy_d     = busy_q;
    clip_d     = 1'b0;
`ifdef GAIN_RAMP_SAT_EN
    rnd        = (acc_q + RND) >>> FR;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          sample_d = in;
          gain_d   = gain_next;   // multiply below uses the slewed gain
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_MULT;
        end
      end
      ST_MULT: begin
        if (gain_q[cnt_q]) begin
          acc_d = acc_q + (sample_ext << cnt_q);
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(GAINSIZE - 1)) begin
          state_d = ST_SAT;
        end
      end
      ST_SAT: begin
`ifdef GAIN_RAMP_SAT_EN
        if (rnd > MAX_V) begin
          out_d  = {1'b0, {(BITSIZE-1){1'b1}}};
          clip_d = 1'b1;
        end else if (rnd < MIN_V) begin
          out_d  = {1'b1, {(BITSIZE-1){1'b0}}};
          clip_d = 1'b1;
        end else begin
          out_d  = rnd[BITSIZE-1:0];
        end
`else
        // Wrapping conversion: keep only the low BITSIZE bits of the rounded value.
        out_d = BITSIZE'((acc_q + RND) >>> FR);
`endif
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge bclk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      lrclk_q  <= 1'b0;
      cnt_q    <= '0;
      sample_q <= '0;
      acc_q    <= '0;
      gain_q   <= '0;
      out_q    <= '0;
      busy_q   <= 1'b0;
      clip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lrclk_q  <= lrclk_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      acc_q    <= acc_d;
      gain_q   <= gain_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      clip_q   <= clip_d;
    end
  end

  assign out  = out_q;
  assign gain = gain_q;
  assign busy = busy_q;
  assign clip = clip_q;

endmodule

// File: tb/tb_gain_ramp.sv
// Purpose: self-checking bench for gain_ramp with a queue scoreboard of expected outputs.
// Latency: expects out/clip GAINSIZE+1 bclk after each sampled lrclk rise.
// Backpressure: none; frames are spaced so no rise lands while busy.
module tb_gain_ramp;
  import gain_ramp_pkg::*;

  typedef struct packed {
    logic [23:0] out;
    logic        clip;
  } exp_t;

  logic        bclk;
  logic        reset;
  logic        lrclk;
  logic [23:0] in_s;
  logic [15:0] target_gain;
  logic        mute;
  logic [23:0] out_w;
  logic [15:0] gain_w;
  logic        busy_w;
  logic        clip_w;

  int          errors;
  int          checks;
  int          gain_m;
  logic [23:0] out_m;
  exp_t        exp_q[$];

  gain_ramp dut (
    .bclk        (bclk),
    .reset       (reset),
    .lrclk       (lrclk),
    .in          (in_s),
    .target_gain (target_gain),
    .mute        (mute),
    .out         (out_w),
    .gain        (gain_w),
    .busy        (busy_w),
    .clip        (clip_w)
  );

  initial begin
    bclk = 1'b0;
    forever #5 bclk = ~bclk;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive a rise, model the slew and expected result, and check the capture edge.
  task automatic start_frame(input logic [23:0] s);
    exp_t   e;
    int     tgt;
    longint p;
    longint r;
    @(negedge bclk);
    in_s  = s;
    lrclk = 1'b1;
    tgt = mute ? 0 : int'(target_gain);
    if (gain_m < tgt) gain_m = (gain_m + 16 > tgt) ? tgt : gain_m + 16;
    else if (gain_m > tgt) gain_m = (gain_m - 16 < tgt) ? tgt : gain_m - 16;
    p = longint'($signed(s)) * longint'(gain_m);
    r = (p + 64'sd8192) >>> 14;
`ifdef GAIN_RAMP_SAT_EN
    if (r > 64'sd8388607) begin
      e.out = 24'h7FFFFF; e.clip = 1'b1;
    end else if (r < -64'sd8388608) begin
      e.out = 24'h800000; e.clip = 1'b1;
    end else begin
      e.out = r[23:0]; e.clip = 1'b0;
    end
`else
    e.out  = r[23:0];
    e.clip = 1'b0;
`endif
    exp_q.push_back(e);
    @(posedge bclk);
    #1;
    lrclk = 1'b0;
    checks++;
    if (busy_w !== 1'b1) begin
      errors++; $display("FAIL capture_busy got %b want 1", busy_w);
    end
    checks++;
    if (gain_w !== gain_m[15:0]) begin
      errors++; $display("FAIL capture_gain got %h want %h", gain_w, gain_m[15:0]);
    end
  endtask

  // Wait (bounded) for the multiply to finish, then pop and compare.
  task automatic finish_frame(input string name);
    exp_t e;
    bit   done;
    done = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(posedge bclk);
      #1;
      if (!busy_w) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL %s_timeout busy got %b want 0", name, busy_w);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (out_w !== e.out) begin
        errors++; $display("FAIL %s_out got %h want %h", name, out_w, e.out);
      end
      checks++;
      if (clip_w !== e.clip) begin
        errors++; $display("FAIL %s_clip got %b want %b", name, clip_w, e.clip);
      end
      out_m = e.out;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; lrclk = 1'b0; mute = 1'b0; in_s = '0; target_gain = '0;
    gain_m = 0; out_m = '0;
    repeat (3) @(posedge bclk);
    #1;
    checks++;
    if ({out_w, gain_w, busy_w, clip_w} !== 42'd0) begin
      errors++;
      $display("FAIL reset_values got out=%h gain=%h busy=%b clip=%b want all 0",
               out_w, gain_w, busy_w, clip_w);
    end
    @(negedge bclk);
    reset = 1'b0;
  endtask

  task automatic test_ramp_up();
    target_gain = UNITY_GAIN;
    for (int i = 1; i <= 1024; i++) begin
      start_frame(24'h100000);
      if (i == 1) begin
        checks++;
        if (gain_w !== 16'h0010) begin
          errors++; $display("FAIL ramp_first_step got %h want 0010", gain_w);
        end
      end
      finish_frame("ramp");
    end
    checks++;
    if (gain_w !== 16'h4000) begin
      errors++; $display("FAIL ramp_reach_unity got %h want 4000", gain_w);
    end
    for (int i = 0; i < 2; i++) begin
      start_frame(24'h100000);
      finish_frame("ramp_hold");
    end
    checks++;
    if (gain_w !== 16'h4000) begin
      errors++; $display("FAIL ramp_hold got %h want 4000", gain_w);
    end
  endtask

  task automatic test_unity_latency();
    logic [23:0] prev;
    exp_t        e;
    prev = out_m;
    start_frame(24'h123456);
    for (int k = 1; k <= 16; k++) begin
      @(posedge bclk);
      #1;
      checks++;
      if (busy_w !== 1'b1 || out_w !== prev) begin
        errors++;
        $display("FAIL latency_E%0d got busy=%b out=%h want busy=1 out=%h", k, busy_w, out_w, prev);
      end
    end
    @(posedge bclk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (busy_w !== 1'b0 || out_w !== 24'h123456 || out_w !== e.out) begin
      errors++;
      $display("FAIL latency_E17 got busy=%b out=%h want busy=0 out=123456", busy_w, out_w);
    end
    out_m = out_w;
    @(posedge bclk);
    #1;
    checks++;
    if (clip_w !== 1'b0) begin
      errors++; $display("FAIL unity_clip got %b want 0", clip_w);
    end
  endtask

  task automatic test_mute();
    int n;
    mute = 1'b1;
    for (int i = 0; i < 512; i++) begin
      start_frame(24'h200000);
      finish_frame("mute_down");
    end
    checks++;
    if (gain_w !== 16'h2000) begin
      errors++; $display("FAIL mute_half got %h want 2000", gain_w);
    end
    mute = 1'b0;
    start_frame(24'h200000);
    finish_frame("unmute");
    checks++;
    if (gain_w !== 16'h2010) begin
      errors++; $display("FAIL mute_reverse got %h want 2010", gain_w);
    end
    mute = 1'b1;
    n = 0;
    while (gain_m != 0 && n < 600) begin
      start_frame(24'h200000);
      finish_frame("mute_zero");
      n++;
    end
    checks++;
    if (n != 513 || gain_w !== 16'h0000) begin
      errors++; $display("FAIL mute_to_zero got frames=%0d gain=%h want frames=513 gain=0000", n, gain_w);
    end
    start_frame(24'h7FFFFF);
    finish_frame("muted");
    checks++;
    if (out_w !== 24'h000000) begin
      errors++; $display("FAIL muted_out got %h want 000000", out_w);
    end
  endtask

  task automatic test_rounding();
    logic [23:0] ins  [3];
    logic [23:0] outs [3];
    ins[0] = 24'h000003; outs[0] = 24'h000002;
    ins[1] = 24'hFFFFFD; outs[1] = 24'hFFFFFF;
    ins[2] = 24'h000001; outs[2] = 24'h000001;
    mute = 1'b0;
    target_gain = 16'h2000;
    for (int i = 0; i < 512; i++) begin
      start_frame(24'h012345);
      finish_frame("to_half");
    end
    checks++;
    if (gain_w !== 16'h2000) begin
      errors++; $display("FAIL half_gain got %h want 2000", gain_w);
    end
    for (int i = 0; i < 3; i++) begin
      start_frame(ins[i]);
      finish_frame("round");
      checks++;
      if (out_w !== outs[i]) begin
        errors++; $display("FAIL round_%0d got %h want %h", i, out_w, outs[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [23:0] want_pos;
    logic [23:0] want_neg;
    logic        want_clip;
`ifdef GAIN_RAMP_SAT_EN
    want_pos = 24'h7FFFFF; want_neg = 24'h800000; want_clip = 1'b1;
`else
    want_pos = 24'hA00000; want_neg = 24'h400000; want_clip = 1'b0;
`endif
    target_gain = 16'h8000;
    for (int i = 0; i < 1536; i++) begin
      start_frame(24'h001000);
      finish_frame("to_double");
    end
    checks++;
    if (gain_w !== 16'h8000) begin
      errors++; $display("FAIL double_gain got %h want 8000", gain_w);
    end
    start_frame(24'h500000);
    finish_frame("ovf_pos");
    checks++;
    if (out_w !== want_pos || clip_w !== want_clip) begin
      errors++; $display("FAIL ovf_pos got out=%h clip=%b want out=%h clip=%b", out_w, clip_w, want_pos, want_clip);
    end
    @(posedge bclk);
    #1;
    checks++;
    if (clip_w !== 1'b0) begin
      errors++; $display("FAIL clip_width got %b want 0", clip_w);
    end
    start_frame(24'hA00000);
    finish_frame("ovf_neg");
    checks++;
    if (out_w !== want_neg || clip_w !== want_clip) begin
      errors++; $display("FAIL ovf_neg got out=%h clip=%b want out=%h clip=%b", out_w, clip_w, want_neg, want_clip);
    end
  endtask

  task automatic test_reset_mid_mult();
    bit bad;
    start_frame(24'h400000);
    repeat (7) @(posedge bclk);
    @(negedge bclk);
    reset = 1'b1;
    @(posedge bclk);
    #1;
    checks++;
    if ({out_w, gain_w, busy_w, clip_w} !== 42'd0) begin
      errors++;
      $display("FAIL mid_reset got out=%h gain=%h busy=%b clip=%b want all 0",
               out_w, gain_w, busy_w, clip_w);
    end
    @(negedge bclk);
    reset = 1'b0;
    gain_m = 0;
    out_m = '0;
    exp_q.delete();
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge bclk);
      #1;
      if (clip_w !== 1'b0 || out_w !== 24'h0 || busy_w !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL post_reset_stale got out=%h clip=%b busy=%b want 0", out_w, clip_w, busy_w);
    end
    start_frame(24'h400000);
    finish_frame("after_reset");
    checks++;
    if (out_w !== 24'h001000 || gain_w !== 16'h0010) begin
      errors++; $display("FAIL after_reset_frame got out=%h gain=%h want out=001000 gain=0010", out_w, gain_w);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_ramp_up();
    test_unity_latency();
    test_mute();
    test_rounding();
    test_overflow();
    test_reset_mid_mult();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
